// File: rtl/xalu_seq.sv
// rtl/xalu_seq.sv - sequential ALU with accumulator, valid/ready handshake and multi-cycle MUL/SHRN/SHLN
// A final FIN cycle applies com, registers result/flags and loads the accumulator.
module xalu_seq #(
  parameter int WIDTH = 8,
  parameter int SW    = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             use_acc,
  input  logic             ci_left,
  input  logic             ci_right,
  input  logic             com,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             co_left,
  output logic             co_right,
  output logic             equ,
  output logic             zero,
  output logic             neg_zero,
  output logic             busy
);

  localparam int CW = SW + 1;

  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_AND  = 4'd1;
  localparam logic [3:0] OP_OR   = 4'd2;
  localparam logic [3:0] OP_XOR  = 4'd3;
  localparam logic [3:0] OP_PASA = 4'd4;
  localparam logic [3:0] OP_PASB = 4'd5;
  localparam logic [3:0] OP_SHR  = 4'd6;
  localparam logic [3:0] OP_SHL  = 4'd7;
  localparam logic [3:0] OP_SUB  = 4'd8;
  localparam logic [3:0] OP_MUL  = 4'd9;
  localparam logic [3:0] OP_SHRN = 4'd10;
  localparam logic [3:0] OP_SHLN = 4'd11;

  typedef enum logic [1:0] {S_IDLE, S_FIN, S_EXEC, S_DONE} state_t;

  state_t           state_q, state_d;
  logic [3:0]       op_q, op_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
  logic             cil_q, cil_d, cir_q, cir_d, com_q, com_d;
  logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d;
  logic             sbit_q, sbit_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] res_q, res_d, acc_q, acc_d;
  logic             col_q, col_d, cor_q, cor_d, equ_q, equ_d;

  logic [WIDTH-1:0] op_a;
  logic [CW-1:0]    n_in;
  logic             multi;
  logic [WIDTH-1:0] b_eff;
  logic [WIDTH:0]   add_sum;
  logic [WIDTH:0]   mul_sum;
  logic [WIDTH-1:0] fin_raw;
  logic             fin_col, fin_cor;

  assign op_a  = use_acc ? acc_q : a;
  assign n_in  = {1'b0, b[SW-1:0]};
  assign multi = (op == OP_MUL) || (((op == OP_SHRN) || (op == OP_SHLN)) && (n_in != '0));

  // SUB reuses the adder: A + ~B + ci_right
  assign b_eff   = (op_q == OP_SUB) ? ~b_q : b_q;
  assign add_sum = {1'b0, a_q} + {1'b0, b_eff} + {{WIDTH{1'b0}}, cir_q};
  assign mul_sum = {1'b0, hi_q} + (lo_q[0] ? {1'b0, a_q} : {(WIDTH+1){1'b0}});

  always_comb begin
    fin_raw = a_q;
    fin_col = 1'b0;
    fin_cor = 1'b0;
    case (op_q)
      OP_ADD, OP_SUB: begin
        fin_raw = add_sum[WIDTH-1:0];
        fin_col = add_sum[WIDTH];
      end
      OP_AND:  fin_raw = a_q & b_q;
      OP_OR:   fin_raw = a_q | b_q;
      OP_XOR:  fin_raw = a_q ^ b_q;
      OP_PASA: fin_raw = a_q;
      OP_PASB: fin_raw = b_q;
      OP_SHR: begin
        fin_raw = {cil_q, a_q[WIDTH-1:1]};
        fin_cor = a_q[0];
      end
      OP_SHL: begin
        fin_raw = {a_q[WIDTH-2:0], cir_q};
        fin_col = a_q[WIDTH-1];
      end
      OP_MUL: begin
        fin_raw = lo_q;
        fin_col = |hi_q;
      end
      OP_SHRN: begin
        fin_raw = lo_q;
        fin_cor = sbit_q;
      end
      OP_SHLN: begin
        fin_raw = lo_q;
        fin_col = sbit_q;
      end
      default: fin_raw = a_q;
    endcase
  end

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    a_d     = a_q;
    b_d     = b_q;
    cil_d   = cil_q;
    cir_d   = cir_q;
    com_d   = com_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    sbit_d  = sbit_q;
    cnt_d   = cnt_q;
    res_d   = res_q;
    acc_d   = acc_q;
    col_d   = col_q;
    cor_d   = cor_q;
    equ_d   = equ_q;
    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          op_d   = op;
          a_d    = op_a;
          b_d    = b;
          cil_d  = ci_left;
          cir_d  = ci_right;
          com_d  = com;
          hi_d   = '0;
          lo_d   = (op == OP_MUL) ? b : op_a;
          sbit_d = 1'b0;
          cnt_d  = (op == OP_MUL) ? CW'(WIDTH) : n_in;
          state_d = multi ? S_EXEC : S_FIN;
        end
      end
      S_EXEC: begin
        if (op_q == OP_MUL) begin
          // shift-add: accumulate into hi, multiplier bits retire out of lo
          hi_d = mul_sum[WIDTH:1];
          lo_d = {mul_sum[0], lo_q[WIDTH-1:1]};
        end else if (op_q == OP_SHRN) begin
          lo_d   = {cil_q, lo_q[WIDTH-1:1]};
          sbit_d = lo_q[0];
        end else begin
          lo_d   = {lo_q[WIDTH-2:0], cir_q};
          sbit_d = lo_q[WIDTH-1];
        end
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) state_d = S_FIN;
      end
      S_FIN: begin
        res_d   = fin_raw ^ {WIDTH{com_q}};
        acc_d   = fin_raw ^ {WIDTH{com_q}};
        col_d   = fin_col;
        cor_d   = fin_cor;
        equ_d   = (a_q == b_q);
        state_d = S_DONE;
      end
      S_DONE: begin
        if (out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      op_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      cil_q   <= 1'b0;
      cir_q   <= 1'b0;
      com_q   <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
      sbit_q  <= 1'b0;
      cnt_q   <= '0;
      res_q   <= '0;
      acc_q   <= '0;
      col_q   <= 1'b0;
      cor_q   <= 1'b0;
      equ_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      cil_q   <= cil_d;
      cir_q   <= cir_d;
      com_q   <= com_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      sbit_q  <= sbit_d;
      cnt_q   <= cnt_d;
      res_q   <= res_d;
      acc_q   <= acc_d;
      col_q   <= col_d;
      cor_q   <= cor_d;
      equ_q   <= equ_d;
    end
  end

  assign in_ready  = (state_q == S_IDLE);
  assign out_valid = (state_q == S_DONE);
  assign busy      = (state_q == S_EXEC);
  assign result    = res_q;
  assign co_left   = col_q;
  assign co_right  = cor_q;
  assign equ       = equ_q;
  assign zero      = (res_q == '0);
  assign neg_zero  = &res_q;

endmodule

// File: tb/tb_xalu_seq.sv
// tb/tb_xalu_seq.sv - directed vector table plus backpressure and mid-MUL reset sequences for xalu_seq
module tb_xalu_seq;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [3:0] op = 4'd0;
  logic [7:0] a = 8'h00, b = 8'h00;
  logic       use_acc = 1'b0, ci_left = 1'b0, ci_right = 1'b0, com = 1'b0;
  logic       out_valid;
  logic       out_ready = 1'b0;
  logic [7:0] result;
  logic       co_left, co_right, equ, zero, neg_zero, busy;

  int errors = 0;
  int checks = 0;

  xalu_seq #(.WIDTH(8)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .op(op), .a(a), .b(b), .use_acc(use_acc), .ci_left(ci_left), .ci_right(ci_right),
    .com(com), .out_valid(out_valid), .out_ready(out_ready), .result(result),
    .co_left(co_left), .co_right(co_right), .equ(equ), .zero(zero),
    .neg_zero(neg_zero), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] op;
    logic [7:0] a;
    logic [7:0] b;
    logic       ua, cil, cir, cm;
    logic [7:0] res;
    logic       col, cor, eq;
    int         lat;
  } vec_t;

  vec_t vt[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, " in_ready"},  in_ready,  1);
    chk({tag, " out_valid"}, out_valid, 0);
    chk({tag, " busy"},      busy,      0);
    chk({tag, " result"},    result,    0);
    chk({tag, " co_left"},   co_left,   0);
    chk({tag, " co_right"},  co_right,  0);
    chk({tag, " equ"},       equ,       0);
    chk({tag, " zero"},      zero,      1);
    chk({tag, " neg_zero"},  neg_zero,  0);
  endtask

  task automatic run_vec(input vec_t t, input int idx);
    int lat;
    string nm;
    nm = $sformatf("v%0d", idx);
    @(negedge clk);
    chk({nm, " in_ready"}, in_ready, 1);
    op = t.op; a = t.a; b = t.b; use_acc = t.ua;
    ci_left = t.cil; ci_right = t.cir; com = t.cm;
    in_valid = 1'b1; out_ready = 1'b0;
    @(posedge clk);
    @(negedge clk);
    // scramble inputs after the accept edge; the op in flight must not notice
    in_valid = 1'b0; a = ~t.a; b = ~t.b; use_acc = ~t.ua;
    ci_left = ~t.cil; ci_right = ~t.cir; com = ~t.cm;
    chk({nm, " busy"}, busy, (t.lat > 1) ? 1 : 0);
    lat = 0;
    while (!out_valid && lat < 200) begin
      @(posedge clk);
      @(negedge clk);
      lat++;
    end
    chk({nm, " latency"},  lat,      t.lat);
    chk({nm, " result"},   result,   t.res);
    chk({nm, " co_left"},  co_left,  t.col);
    chk({nm, " co_right"}, co_right, t.cor);
    chk({nm, " equ"},      equ,      t.eq);
    chk({nm, " zero"},     zero,     (t.res == 8'h00) ? 1 : 0);
    chk({nm, " neg_zero"}, neg_zero, (t.res == 8'hFF) ? 1 : 0);
    chk({nm, " in_ready_done"}, in_ready, 0);
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    chk({nm, " out_valid_after"}, out_valid, 0);
  endtask

  initial begin
    #400000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    //             op     a      b      ua cil cir com res    col cor equ lat
    vt.push_back('{4'd0,  8'hF0, 8'h20, 0, 0, 1, 0, 8'h11, 1, 0, 0, 1});
    vt.push_back('{4'd0,  8'hF0, 8'h20, 0, 0, 1, 1, 8'hEE, 1, 0, 0, 1});
    vt.push_back('{4'd9,  8'h0F, 8'h11, 0, 0, 0, 0, 8'hFF, 0, 0, 0, 9});
    vt.push_back('{4'd9,  8'h10, 8'h10, 0, 0, 0, 0, 8'h00, 1, 0, 1, 9});
    vt.push_back('{4'd10, 8'h81, 8'h03, 0, 1, 0, 0, 8'hF0, 0, 0, 0, 4});
    vt.push_back('{4'd11, 8'h81, 8'h00, 0, 0, 0, 0, 8'h81, 0, 0, 0, 1});
    vt.push_back('{4'd5,  8'h33, 8'h05, 0, 0, 0, 0, 8'h05, 0, 0, 0, 1});
    vt.push_back('{4'd0,  8'hAA, 8'h03, 1, 0, 0, 0, 8'h08, 0, 0, 0, 1});
    vt.push_back('{4'd8,  8'hAA, 8'h08, 1, 0, 1, 0, 8'h00, 1, 0, 1, 1});
    vt.push_back('{4'd1,  8'hCC, 8'hAA, 0, 0, 0, 0, 8'h88, 0, 0, 0, 1});
    vt.push_back('{4'd2,  8'hCC, 8'hAA, 0, 0, 0, 0, 8'hEE, 0, 0, 0, 1});
    vt.push_back('{4'd3,  8'hCC, 8'hAA, 0, 0, 0, 0, 8'h66, 0, 0, 0, 1});
    vt.push_back('{4'd6,  8'h81, 8'h00, 0, 0, 0, 0, 8'h40, 0, 1, 0, 1});
    vt.push_back('{4'd7,  8'h81, 8'h00, 0, 0, 1, 0, 8'h03, 1, 0, 0, 1});
    vt.push_back('{4'd8,  8'h05, 8'h08, 0, 0, 1, 0, 8'hFD, 0, 0, 0, 1});
    vt.push_back('{4'd13, 8'h5A, 8'h12, 0, 0, 0, 0, 8'h5A, 0, 0, 0, 1});
    vt.push_back('{4'd11, 8'h41, 8'h02, 0, 0, 0, 0, 8'h04, 1, 0, 0, 3});
    vt.push_back('{4'd10, 8'hC0, 8'h07, 0, 0, 0, 0, 8'h01, 0, 1, 0, 8});

    repeat (2) @(negedge clk);
    chk_reset_outputs("reset");
    rst_n = 1'b1;

    foreach (vt[i]) run_vec(vt[i], i);

    // backpressure: ADD 0x12+0x34 held with out_ready low while new requests arrive
    @(negedge clk);
    op = 4'd0; a = 8'h12; b = 8'h34; use_acc = 0; ci_left = 0; ci_right = 0; com = 0;
    in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("bp out_valid", out_valid, 1);
    for (int c = 0; c < 5; c++) begin
      in_valid = c[0] ? 1'b0 : 1'b1;
      op = 4'd5; a = 8'h90 + 8'(c); b = 8'hA0 + 8'(c);
      @(posedge clk);
      @(negedge clk);
      chk($sformatf("bp result c%0d", c), result, 8'h46);
      chk($sformatf("bp in_ready c%0d", c), in_ready, 0);
      chk($sformatf("bp out_valid c%0d", c), out_valid, 1);
    end
    in_valid = 1'b1;
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    out_ready = 1'b0;
    chk("bp release out_valid", out_valid, 0);
    chk("bp release in_ready", in_ready, 1);
    @(posedge clk);
    @(negedge clk);
    chk("bp no extra op", in_ready, 1);
    chk("bp no extra busy", busy, 0);

    // reset during MUL EXEC
    @(negedge clk);
    op = 4'd9; a = 8'h0F; b = 8'h11; in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (2) begin
      @(posedge clk);
      @(negedge clk);
    end
    chk("rst busy before", busy, 1);
    #1 rst_n = 1'b0;
    #1 chk_reset_outputs("midmul");
    repeat (2) @(negedge clk);
    chk_reset_outputs("midmul hold");
    rst_n = 1'b1;

    run_vec('{4'd0, 8'h77, 8'h01, 1, 0, 0, 0, 8'h01, 0, 0, 0, 1}, 100);
    run_vec('{4'd0, 8'h01, 8'h01, 0, 0, 0, 0, 8'h02, 0, 0, 1, 1}, 101);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
